// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB with MDU busy interlock and MEM timeout.
// Outputs are combinational from state and instruction fields; MEM waits on mem_ready, DECODE stalls on MDU busy.
module mc_ctrl #(
   parameter int MDU_LAT     = 5,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic       alu_src,
   output logic       ext_op,
   output logic       mem_write,
   output logic       mdu_start,
   output logic       illegal,
   output logic       mem_timeout,
   output logic [1:0] reg_dst,
   output logic [1:0] mem_to_reg,
   output logic [1:0] pc_src,
   output logic [2:0] alu_op,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_e;

   typedef enum logic [3:0] {
      I_ADDU, I_SUBU, I_SLL, I_JR, I_MULT, I_MULTU, I_MFHI, I_MFLO,
      I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_JAL, I_ILL
   } instr_e;

   localparam logic [4:0] MDU_LAT_C = MDU_LAT[4:0];
   localparam logic [7:0] MEM_LAST  = 8'(MEM_TIMEOUT - 1);

   state_e     state_q, state_d;
   logic [4:0] mdu_cnt_q, mdu_cnt_d;
   logic [7:0] mem_cnt_q, mem_cnt_d;
   logic       timeout_q, timeout_set;

   instr_e     ins;
   logic [2:0] alu_op_c;
   logic       alu_src_c;
   logic       ext_op_c;
   logic       mdu_dep;

   always_comb begin
      ins = I_ILL;
      case (op)
         6'h00: begin
            case (funct)
               6'h21:   ins = I_ADDU;
               6'h23:   ins = I_SUBU;
               6'h00:   ins = I_SLL;
               6'h08:   ins = I_JR;
               6'h18:   ins = I_MULT;
               6'h19:   ins = I_MULTU;
               6'h10:   ins = I_MFHI;
               6'h12:   ins = I_MFLO;
               default: ins = I_ILL;
            endcase
         end
         6'h0D:   ins = I_ORI;
         6'h23:   ins = I_LW;
         6'h2B:   ins = I_SW;
         6'h04:   ins = I_BEQ;
         6'h0F:   ins = I_LUI;
         6'h03:   ins = I_JAL;
         default: ins = I_ILL;
      endcase
   end

   always_comb begin
      alu_op_c  = 3'b000;
      alu_src_c = 1'b0;
      ext_op_c  = 1'b0;
      case (ins)
         I_ADDU, I_LW, I_SW: alu_op_c = 3'b010;
         I_SUBU, I_BEQ:      alu_op_c = 3'b110;
         I_ORI:              alu_op_c = 3'b001;
         I_LUI:              alu_op_c = 3'b111;
         I_SLL:              alu_op_c = 3'b011;
         default:            alu_op_c = 3'b000;
      endcase
      alu_src_c = (ins == I_ORI) || (ins == I_LW) || (ins == I_SW) || (ins == I_LUI);
      ext_op_c  = (ins == I_ORI);
   end

   // Instructions that read or write hi/lo must wait for the multiplier to drain.
   assign mdu_dep = (ins == I_MULT) || (ins == I_MULTU) || (ins == I_MFHI) || (ins == I_MFLO);

   always_comb begin
      state_d     = state_q;
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      alu_src     = 1'b0;
      ext_op      = 1'b0;
      mem_write   = 1'b0;
      mdu_start   = 1'b0;
      illegal     = 1'b0;
      reg_dst     = 2'd0;
      mem_to_reg  = 2'd0;
      pc_src      = 2'd0;
      alu_op      = 3'b000;
      timeout_set = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
         end
         S_DECODE: begin
            if (ins == I_ILL) begin
               illegal = 1'b1;
               state_d = S_FETCH;
            end else if (mdu_dep && (mdu_cnt_q != 5'd0)) begin
               state_d = S_DECODE;
            end else if (ins == I_JAL) begin
               pc_write   = 1'b1;
               pc_src     = 2'd2;
               reg_write  = 1'b1;
               reg_dst    = 2'd2;
               mem_to_reg = 2'd2;
               state_d    = S_FETCH;
            end else if (ins == I_JR) begin
               pc_write = 1'b1;
               pc_src   = 2'd3;
               state_d  = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            alu_op  = alu_op_c;
            alu_src = alu_src_c;
            ext_op  = ext_op_c;
            case (ins)
               I_BEQ: begin
                  pc_write = zero;
                  pc_src   = 2'd1;
                  state_d  = S_FETCH;
               end
               I_MULT, I_MULTU: begin
                  mdu_start = 1'b1;
                  state_d   = S_FETCH;
               end
               I_LW, I_SW: state_d = S_MEM;
               default:    state_d = S_WB;
            endcase
         end
         S_MEM: begin
            alu_op    = alu_op_c;
            alu_src   = alu_src_c;
            ext_op    = ext_op_c;
            mem_write = (ins == I_SW);
            // A timed-out access retires exactly as if memory had answered.
            timeout_set = !mem_ready && (mem_cnt_q == MEM_LAST);
            if (mem_ready || timeout_set) begin
               state_d = (ins == I_LW) ? S_WB : S_FETCH;
            end
         end
         S_WB: begin
            alu_op    = alu_op_c;
            alu_src   = alu_src_c;
            ext_op    = ext_op_c;
            reg_write = 1'b1;
            reg_dst   = (ins == I_ADDU || ins == I_SUBU || ins == I_SLL ||
                         ins == I_MFHI || ins == I_MFLO) ? 2'd1 : 2'd0;
            if (ins == I_LW)                         mem_to_reg = 2'd1;
            else if (ins == I_MFHI || ins == I_MFLO) mem_to_reg = 2'd3;
            else                                     mem_to_reg = 2'd0;
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      if (reset) begin
         state_d     = S_FETCH;
         pc_write    = 1'b0;
         ir_write    = 1'b0;
         reg_write   = 1'b0;
         alu_src     = 1'b0;
         ext_op      = 1'b0;
         mem_write   = 1'b0;
         mdu_start   = 1'b0;
         illegal     = 1'b0;
         reg_dst     = 2'd0;
         mem_to_reg  = 2'd0;
         pc_src      = 2'd0;
         alu_op      = 3'b000;
         timeout_set = 1'b0;
      end
   end

   always_comb begin
      if (mdu_start)               mdu_cnt_d = MDU_LAT_C;
      else if (mdu_cnt_q != 5'd0)  mdu_cnt_d = mdu_cnt_q - 5'd1;
      else                         mdu_cnt_d = 5'd0;
      mem_cnt_d = ((state_q == S_MEM) && (state_d == S_MEM)) ? mem_cnt_q + 8'd1 : 8'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         mdu_cnt_q <= 5'd0;
         mem_cnt_q <= 8'd0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mdu_cnt_q <= mdu_cnt_d;
         mem_cnt_q <= mem_cnt_d;
         timeout_q <= timeout_q | timeout_set;
      end
   end

   assign mem_timeout = timeout_q & ~reset;
   assign state       = state_q;

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter MDU_LAT, default 5, multiply-busy cycles after a mult/multu issues (legal range 1..31).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, maximum MEM-state wait cycles before forced exit (legal range 1..255).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port op  input  6  instruction bits [31:26], sampled while ir_write=0.
REQ-006 SHALL have port funct  input  6  instruction bits [5:0].
REQ-007 SHALL have port zero  input  1  ALU equality result, valid in EXEC.
REQ-008 SHALL have port mem_ready  input  1  data-memory completion, sampled in MEM.
REQ-009 SHALL have outputs pc_write, ir_write, reg_write, alu_src, ext_op, mem_write, mdu_start, illegal, mem_timeout, each 1 bit.
REQ-010 SHALL have outputs reg_dst 2 (0 rt, 1 rd, 2 r31), mem_to_reg 2 (0 ALU, 1 mem, 2 PC+4, 3 hi/lo), pc_src 2 (0 PC+4, 1 branch, 2 jump target, 3 rs), alu_op 3, state 3.

Function
REQ-011 SHALL decode, with op=0: addu funct 0x21, subu 0x23, sll 0x00, jr 0x08, mult 0x18, multu 0x19, mfhi 0x10, mflo 0x12; and by op: ori 0x0D, lw 0x23, sw 0x2B, beq 0x04, lui 0x0F, jal 0x03.
REQ-012 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, driven on state.
REQ-013 SHALL in FETCH assert ir_write=1, pc_write=1, pc_src=0 for exactly one cycle, then go to DECODE.
REQ-014 SHALL in DECODE complete jal (pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2) and jr (pc_write=1, pc_src=3), returning to FETCH; other legal opcodes go to EXEC.
REQ-015 SHALL use alu_op addu/lw/sw 3'b010, subu/beq 3'b110, ori 3'b001, lui 3'b111, sll 3'b011, others 3'b000; alu_src=1 for ori/lw/sw/lui; ext_op=1 only for ori; alu_op/alu_src/ext_op held valid in EXEC, MEM and WB.
REQ-016 SHALL in EXEC for beq assert pc_write=zero, pc_src=1, then FETCH; mult/multu assert mdu_start=1 for one cycle, then FETCH; lw/sw go to MEM; the rest go to WB.
REQ-017 SHALL in MEM hold state while mem_ready=0, asserting mem_write=1 every MEM cycle for sw; on mem_ready=1, lw goes to WB, sw to FETCH.
REQ-018 SHALL count MEM cycles; if MEM_TIMEOUT cycles elapse without mem_ready, set sticky mem_timeout=1 and exit as if mem_ready=1 that cycle.
REQ-019 SHALL in WB assert reg_write=1 for one cycle: reg_dst=1 for addu/subu/sll/mfhi/mflo, else 0; mem_to_reg=1 lw, 3 mfhi/mflo, else 0; then FETCH.
REQ-020 SHALL keep an MDU busy counter: loaded with MDU_LAT on the mdu_start cycle, decremented by 1 each cycle while nonzero, saturating at 0.
REQ-021 SHALL stall in DECODE (no outputs asserted) while counter != 0 and the instruction is mult/multu/mfhi/mflo; it proceeds the cycle after counter reaches 0.
REQ-022 SHALL for an undecoded op/funct pulse illegal=1 in DECODE for one cycle, write nothing, and return to FETCH (nop).
REQ-023 SHALL deassert every enable not named for the current state/instruction; reg_write and mem_write SHALL never both be 1.

Reset
REQ-024 SHALL on reset=1 at a clock edge enter FETCH, clear busy counter, MEM counter, mem_timeout, and drive all outputs 0 except those REQ-013 mandates in FETCH the following cycle.
REQ-025 SHALL abort any instruction mid-flight on reset (including MEM wait and MDU stall), no write enable asserted in the reset cycle.

Verification
REQ-026 addu (op 0, funct 0x21) after reset -> states 0,1,2,4,0; reg_write=1, reg_dst=1 only in WB; 4 cycles.
REQ-027 lw with mem_ready low 3 cycles then high -> MEM held 4 cycles, then WB with mem_to_reg=1; total 8 cycles.
REQ-028 beq with zero=1 then zero=0 -> pc_write=1 pc_src=1 in first EXEC, pc_write=0 in second; each 3 cycles.
REQ-029 mult then mflo immediately, MDU_LAT=5 -> mdu_start one cycle; mflo stalls in DECODE until counter 0, then WB with mem_to_reg=3.
REQ-030 sw with mem_ready stuck 0, MEM_TIMEOUT=15 -> 15 MEM cycles with mem_write=1, mem_timeout=1 sticky, FETCH next; reset clears it.
REQ-031 op=0x3F; and reset asserted mid-MEM -> illegal pulse one cycle, no writes; reset returns state=0 next cycle, all enables 0.
